alu_nbit_seq: RTL and testbench

Parametrised, registered ALU that succeeds the 32-bit combinational ALU. Width is a parameter. Operands enter through a valid/ready handshake, and results leave through a second valid/ready handshake together with a flag set. The block keeps the legacy M/S1/S0 operation encoding, adds shifts and a multi-cycle shift-add multiply, and sits between the operand-fetch stage and the writeback register in the datapath.

---
 rtl/alu_nbit_seq.sv | 108 ++++++++++
 tb/tb_alu_nbit_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq: registered WIDTH-bit ALU with valid/ready handshakes and a shift-add multiply
module alu_nbit_seq #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);
  typedef enum logic {IDLE, MUL} state_t;
  localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH-1);
  state_t state, state_nxt;
  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [WIDTH-1:0] mplier, y, r;
  logic [SHW:0] cnt;
  logic [SHW-1:0] sh;
  logic [WIDTH:0] sum, sll, srl, sra;
  logic in_xfer, is_mul, last, ld, c, v, e;
  assign in_xfer = in_valid && in_ready;
  assign is_mul = op == 4'b1000;
  assign last = cnt == LAST;
  assign ld = state == IDLE ? in_xfer && !is_mul : last;
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (in_xfer && is_mul ? MUL : IDLE) : (last ? IDLE : MUL);
  always_comb
    in_ready = state == IDLE && (!out_valid || out_ready);
  always_comb begin
    sh = b[SHW-1:0];
    y = (op[1] ^ op[0]) ? b : WIDTH'(1);
    sum = op[0] ? {1'b0, a} + {1'b0, y} : {1'b0, a} - {1'b0, y};
    sll = {1'b0, a} << sh;
    srl = {a, 1'b0} >> sh;
    sra = $signed({a, 1'b0}) >>> sh;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    e = 1'b0;
    casez (op)
      4'b0000: r = ~a;
      4'b0001: r = a & b;
      4'b0010: r = a ^ b;
      4'b0011: r = a | b;
      4'b01??: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (a[WIDTH-1] ^ y[WIDTH-1] ^ op[0]) && (sum[WIDTH-1] ^ a[WIDTH-1]);
      end
      4'b1000: r = '0;
      4'b1001: {c, r} = sll;
      4'b1010: {r, c} = srl;
      4'b1011: {r, c} = sra;
      default: e = 1'b1;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      result <= '0;
      zero <= 1'b0;
      neg <= 1'b0;
      carry <= 1'b0;
      ovf <= 1'b0;
      err <= 1'b0;
    end else begin
      if (ld) begin
        result <= state == MUL ? acc_nxt[WIDTH-1:0] : r;
        zero <= (state == MUL ? acc_nxt[WIDTH-1:0] : r) == '0;
        neg <= state == MUL ? acc_nxt[WIDTH-1] : r[WIDTH-1];
        carry <= state == MUL ? 1'b0 : c;
        ovf <= state == MUL ? |acc_nxt[2*WIDTH-1:WIDTH] : v;
        err <= state == MUL ? 1'b0 : e;
      end
      out_valid <= ld || (out_valid && !out_ready);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (state == IDLE && in_xfer && is_mul) begin
      mcand <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc <= '0;
      cnt <= '0;
    end else if (state == MUL) begin
      acc <= acc_nxt;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + (SHW+1)'(1);
    end
endmodule

// File: tb/tb_alu_nbit_seq.sv
// tb_alu_nbit_seq: scoreboard bench for alu_nbit_seq against an arithmetic reference model
module tb_alu_nbit_seq;
  typedef struct packed {
    logic [31:0] r;
    logic z, n, c, v, e;
  } rsp_t;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] op;
  logic [31:0] a, b, result;
  logic zero, neg, carry, ovf, err;
  rsp_t sb[$];
  rsp_t outs;
  int asserts = 0, fails = 0;
  bit rnd_ready = 0;
  alu_nbit_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero), .neg(neg),
    .carry(carry), .ovf(ovf), .err(err)
  );
  assign outs = {result, zero, neg, carry, ovf, err};
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic rsp_t model(logic [3:0] o, logic [31:0] x, logic [31:0] y);
    rsp_t q;
    longint s;
    logic [63:0] p;
    int n;
    q = '0;
    s = 0;
    n = int'(y[4:0]);
    case (o)
      0: q.r = ~x;
      1: q.r = x & y;
      2: q.r = x ^ y;
      3: q.r = x | y;
      4: begin q.r = x - 1; q.c = x == 0; s = longint'($signed(x)) - 1; end
      5: begin q.r = x + y; q.c = (64'(x) + 64'(y)) > 64'hFFFF_FFFF; s = longint'($signed(x)) + longint'($signed(y)); end
      6: begin q.r = x - y; q.c = x < y; s = longint'($signed(x)) - longint'($signed(y)); end
      7: begin q.r = x + 1; q.c = x == 32'hFFFF_FFFF; s = longint'($signed(x)) + 1; end
      8: begin p = 64'(x) * 64'(y); q.r = p[31:0]; q.v = p[63:32] != 0; end
      9: begin q.r = x << n; q.c = n == 0 ? 1'b0 : x[32-n]; end
      10: begin q.r = x >> n; q.c = n == 0 ? 1'b0 : x[n-1]; end
      11: begin q.r = $signed(x) >>> n; q.c = n == 0 ? 1'b0 : x[n-1]; end
      default: q.e = 1;
    endcase
    if (o >= 4 && o <= 7) q.v = s > 64'sd2147483647 || s < -64'sd2147483648;
    q.z = q.r == 0;
    q.n = q.r[31];
    return q;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction
  task automatic send(logic [3:0] o, logic [31:0] x, logic [31:0] y);
    int t = 0;
    @(negedge clk);
    op = o;
    a = x;
    b = y;
    in_valid = 1;
    #1;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    sb.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask
  task automatic measure(output int n, output bit ir_bad);
    n = 0;
    ir_bad = 0;
    while (!out_valid && n < 100) begin
      if (in_ready) ir_bad = 1;
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  initial begin
    bit pv = 0, pr = 0;
    rsp_t prev, exp;
    forever begin
      @(negedge clk);
      #2;
      if (rst) pv = 0;
      else begin
        if (pv && !pr) chk("hold", {out_valid, outs}, {1'b1, prev});
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("unexpected_output", {1'b1, outs}, 0);
          else begin
            exp = sb.pop_front();
            chk("result", outs, exp);
          end
        end
        pv = out_valid;
        pr = out_ready;
        prev = outs;
      end
    end
  end
  always @(negedge clk) if (rnd_ready) out_ready = $urandom_range(0, 3) != 0;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, seen;
    bit irb;
    rst = 1;
    in_valid = 0;
    op = 0;
    a = 0;
    b = 0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 0;
    #1 chk("reset_state", {out_valid, in_ready, outs}, {1'b0, 1'b1, 37'b0});
    send(4'b0000, 5, 0);
    measure(lat, irb);
    chk("not_latency", lat, 0);
    chk("not_value", outs, {32'hFFFF_FFFA, 5'b01000});
    send(4'b0101, 32'h7FFF_FFFF, 1);
    send(4'b0110, 32'h8000_0000, 1);
    send(4'b0110, 30, 30);
    send(4'b1000, 32'h0001_0000, 32'h0001_0000);
    measure(lat, irb);
    chk("mul_latency", lat, 32);
    chk("mul_in_ready_low", irb, 0);
    send(4'b1000, 123, 456);
    measure(lat, irb);
    chk("mul2_latency", lat, 32);
    chk("mul2_in_ready_low", irb, 0);
    chk("mul2_value", result, 56088);
    send(4'b1011, 32'h8000_0000, 4);
    send(4'b1001, 32'h8000_0001, 1);
    send(4'b1010, 32'hDEAD_BEEF, 32);
    send(4'b1110, $urandom, $urandom);
    repeat (2) @(posedge clk);
    @(negedge clk) out_ready = 0;
    send(4'b0101, 10, 20);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", {out_valid, in_ready, result}, {1'b1, 1'b0, 32'd30});
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    send(4'b0001, 5, 3);
    chk("bp_next", {out_valid, result}, {1'b1, 32'd1});
    send(4'b1000, $urandom, $urandom);
    repeat (10) @(posedge clk);
    #1 rst = 1;
    void'(sb.pop_back());
    #1 chk("rst_mid_mul", {out_valid, in_ready, outs}, {1'b0, 1'b1, 37'b0});
    @(negedge clk) rst = 0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    chk("no_output_after_rst", seen, 0);
    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(4'($urandom_range(0, 15)), pick(), pick());
    end
    @(negedge clk);
    rnd_ready = 0;
    out_ready = 1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
